// File: rtl/crcn_stream_engine.sv
// Parametrised TinyQV-mapped CRC engine: byte FIFO feeding a bit-serial CRC folder.
// Build option CRCN_DONE_IRQ_EN adds a sticky completion interrupt on user_interrupt.
module crcn_stream_engine #(
  parameter int          CRC_W          = 32,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] POLY_DEFAULT   = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int NSTEP = 8 / BITS_PER_CYCLE;

  localparam logic [5:0] A_CTRL = 6'h00;
  localparam logic [5:0] A_CFG  = 6'h04;
  localparam logic [5:0] A_DATA = 6'h08;
  localparam logic [5:0] A_RES  = 6'h0C;
  localparam logic [5:0] A_POLY = 6'h10;
  localparam logic [5:0] A_INIT = 6'h14;
  localparam logic [5:0] A_STAT = 6'h18;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  function automatic logic [CRC_W-1:0] rev_w(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Bus decode
  logic wr_en, rd_en, wr_ctrl, wr_cfg, wr_data, wr_poly, wr_init, clear;
  logic [2:0]  wr_nbytes;
  logic [31:0] lane_m, poly_wr32, init_wr32;

  assign wr_en   = (data_write_n != 2'b11);
  assign rd_en   = (data_read_n != 2'b11);
  assign wr_ctrl = wr_en && (address == A_CTRL);
  assign wr_cfg  = wr_en && (address == A_CFG);
  assign wr_data = wr_en && (address == A_DATA);
  assign wr_poly = wr_en && (address == A_POLY);
  assign wr_init = wr_en && (address == A_INIT);
  assign clear   = wr_ctrl && data_in[1];

  assign wr_nbytes = (data_write_n == 2'b00) ? 3'd1 : (data_write_n == 2'b01) ? 3'd2 : 3'd4;
  assign lane_m    = (data_write_n == 2'b00) ? 32'h0000_00FF :
                     (data_write_n == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

  // Register file
  logic             enable_q, ovf_q;
  logic [2:0]       cfg_q;
  logic [CRC_W-1:0] poly_q, init_q;

  assign poly_wr32 = (32'(poly_q) & ~lane_m) | (data_in & lane_m);
  assign init_wr32 = (32'(init_q) & ~lane_m) | (data_in & lane_m);

  // FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, ovf_set, pop, fifo_empty, fifo_full;
  logic [7:0]    head;

  assign push_ok    = wr_data && ((int'(count_q) + int'(wr_nbytes)) <= FIFO_DEPTH);
  assign ovf_set    = wr_data && !push_ok;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr_q];

  // Engine
  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       sh_q, sh_d, sh_f;
  logic [CRC_W-1:0] crc_q, crc_d, crc_f, poly_act_q, poly_act_d;
  logic             fb, busy;

  assign busy = (state_q == ST_SHIFT);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sh_d       = sh_q;
    crc_d      = crc_q;
    poly_act_d = poly_act_q;
    pop        = 1'b0;
    fb         = 1'b0;
    crc_f      = crc_q;
    sh_f       = sh_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      fb    = crc_f[CRC_W-1] ^ sh_f[7];
      crc_f = {crc_f[CRC_W-2:0], 1'b0} ^ (fb ? poly_act_q : '0);
      sh_f  = {sh_f[6:0], 1'b0};
    end
    case (state_q)
      ST_IDLE: begin
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        crc_d  = crc_f;
        sh_d   = sh_f;
        step_d = step_q - 3'd1;
        if (step_q == 3'd0) begin
          if (enable_q && !fifo_empty) pop = 1'b1;
          else                          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Byte boundary: latch the next byte and the polynomial it is folded with.
    if (pop) begin
      sh_d       = cfg_q[0] ? rev8(head) : head;
      step_d     = 3'(NSTEP - 1);
      poly_act_d = poly_q;
    end
    if (clear) begin
      state_d = ST_IDLE;
      crc_d   = init_q;
      pop     = 1'b0;
    end
  end

  always_comb begin
    count_d  = count_q + CW'(push_ok ? wr_nbytes : 3'd0) - CW'(pop);
    wr_ptr_d = wr_ptr_q + (push_ok ? AW'(wr_nbytes) : '0);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (push_ok && (i < int'(wr_nbytes)))
        fifo_mem[wr_ptr_q + AW'(i)] <= data_in[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q   <= 1'b0;
      cfg_q      <= 3'b111;
      poly_q     <= POLY_DEFAULT[CRC_W-1:0];
      init_q     <= '1;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      step_q     <= '0;
      sh_q       <= '0;
      crc_q      <= '1;
      poly_act_q <= POLY_DEFAULT[CRC_W-1:0];
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (wr_ctrl) enable_q <= data_in[0];
      if (wr_cfg)  cfg_q    <= data_in[2:0];
      if (wr_poly) poly_q   <= poly_wr32[CRC_W-1:0];
      if (wr_init) init_q   <= init_wr32[CRC_W-1:0];
      if (clear)        ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      state_q    <= state_d;
      step_q     <= step_d;
      sh_q       <= sh_d;
      crc_q      <= crc_d;
      poly_act_q <= poly_act_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Read side
  logic [CRC_W-1:0] crc_out;
  assign crc_out = (cfg_q[1] ? rev_w(crc_q) : crc_q) ^ (cfg_q[2] ? '1 : '0);

  always_comb begin
    data_out = '0;
    case (address)
      A_CTRL: data_out = {31'b0, enable_q};
      A_CFG:  data_out = {29'b0, cfg_q};
      A_RES:  data_out = 32'(crc_out);
      A_POLY: data_out = 32'(poly_q);
      A_INIT: data_out = 32'(init_q);
      A_STAT: data_out = {20'b0, 8'(count_q), ovf_q, fifo_full, fifo_empty, busy};
      default: data_out = '0;
    endcase
  end

  // RESULT stalls only while enabled work is still outstanding.
  assign data_ready = !(rd_en && (address == A_RES) && enable_q && (busy || !fifo_empty));
  assign uo_out     = {6'b0, fifo_full, busy};

`ifdef CRCN_DONE_IRQ_EN
  logic irq_q, irq_set, irq_clr;
  assign irq_set = busy && (state_d == ST_IDLE) && (count_d == '0) && enable_q;
  assign irq_clr = clear || (wr_ctrl && data_in[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_q <= 1'b0;
    else if (irq_set) irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end
  assign user_interrupt = irq_q;
`else
  assign user_interrupt = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, poly_wr32, init_wr32};

endmodule

// File: tb/tb_crcn_stream_engine.sv
// Bench for crcn_stream_engine: six instances across CRC widths and bits-per-cycle,
// checked against a textbook bit-at-a-time CRC model.
module tb_crcn_stream_engine;

  localparam int ND = 6;
  localparam logic [5:0] A_CTRL = 6'h00, A_CFG = 6'h04, A_DATA = 6'h08, A_RES = 6'h0C;
  localparam logic [5:0] A_POLY = 6'h10, A_INIT = 6'h14, A_STAT = 6'h18;

  function automatic int wid_of(input int g);
    case (g)
      4:       return 16;
      5:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int bpc_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 8;
      4:       return 4;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [5:0]  address [ND];
  logic [31:0] data_in [ND];
  logic [1:0]  wr_n [ND];
  logic [1:0]  rd_n [ND];
  logic [7:0]  uo_out [ND];
  logic [31:0] data_out [ND];
  logic        data_ready [ND];
  logic        irq [ND];

  int vectors = 0;
  int errors  = 0;
  logic [7:0] msg_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    crcn_stream_engine #(
      .CRC_W(wid_of(g)), .FIFO_DEPTH(8), .BITS_PER_CYCLE(bpc_of(g)), .POLY_DEFAULT(32'h04C11DB7)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out[g]),
      .address(address[g]), .data_in(data_in[g]), .data_write_n(wr_n[g]),
      .data_read_n(rd_n[g]), .data_out(data_out[g]), .data_ready(data_ready[g]),
      .user_interrupt(irq[g])
    );
  end

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference CRC over msg_q: plain shift-register long division, one message bit at a time.
  function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [2:0] cfg);
    logic [31:0] m, c, r;
    logic        bi, top;
    m = mask_of(w);
    c = init & m;
    foreach (msg_q[j]) begin
      for (int i = 7; i >= 0; i--) begin
        bi  = cfg[0] ? msg_q[j][7-i] : msg_q[j][i];
        top = c[w-1] ^ bi;
        c   = (c << 1) & m;
        if (top) c = c ^ (poly & m);
      end
    end
    if (cfg[1]) begin
      r = '0;
      for (int i = 0; i < w; i++) r[i] = c[w-1-i];
      c = r;
    end
    if (cfg[2]) c = c ^ m;
    return c;
  endfunction

  task automatic bus_write(input int k, input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    @(posedge clk); #1;
    address[k] = a; data_in[k] = d; wr_n[k] = wn;
    @(posedge clk); #1;
    wr_n[k] = 2'b11;
  endtask

  task automatic bus_read(input int k, input logic [5:0] a, output logic [31:0] d);
    int cyc;
    @(posedge clk); #1;
    address[k] = a; rd_n[k] = 2'b10;
    #1;
    cyc = 0;
    while (!data_ready[k] && cyc < 1000) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (!data_ready[k]) begin
      vectors++; errors++;
      $display("FAIL read_timeout dut%0d addr=%h: data_ready=0 after %0d cycles, required 1", k, a, cyc);
    end
    d = data_out[k];
    @(posedge clk); #1;
    rd_n[k] = 2'b11;
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic [1:0] wn);
    int n, tries;
    logic [31:0] st;
    n = (wn == 2'b00) ? 1 : (wn == 2'b01) ? 2 : 4;
    tries = 0;
    do begin
      bus_read(k, A_STAT, st);
      tries++;
    end while ((8 - int'(st[11:4])) < n && tries < 500);
    if ((8 - int'(st[11:4])) < n) begin
      vectors++; errors++;
      $display("FAIL push_wait dut%0d: fifo count %0d, required room for %0d", k, st[11:4], n);
    end
    bus_write(k, A_DATA, d, wn);
    for (int i = 0; i < n; i++) msg_q.push_back(d[8*i +: 8]);
  endtask

  task automatic setup(input int k, input logic [31:0] poly, input logic [31:0] init, input logic [2:0] cfg);
    bus_write(k, A_POLY, poly, 2'b10);
    bus_write(k, A_INIT, init, 2'b10);
    bus_write(k, A_CFG, {29'b0, cfg}, 2'b10);
    bus_write(k, A_CTRL, 32'h3, 2'b10);
    msg_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r, m;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < ND; k++) begin
      m = mask_of(wid_of(k));
      vectors++;
      if (uo_out[k] !== 8'h00 || irq[k] !== 1'b0) begin
        errors++; $display("FAIL reset_pins dut%0d: uo_out=%h irq=%b, required 00/0", k, uo_out[k], irq[k]);
      end
      bus_read(k, A_CTRL, r); vectors++;
      if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl dut%0d: got %h, required 0", k, r); end
      bus_read(k, A_CFG, r); vectors++;
      if (r !== 32'h7) begin errors++; $display("FAIL reset_config dut%0d: got %h, required 7", k, r); end
      bus_read(k, A_POLY, r); vectors++;
      if (r !== (32'h04C11DB7 & m)) begin errors++; $display("FAIL reset_poly dut%0d: got %h, required %h", k, r, 32'h04C11DB7 & m); end
      bus_read(k, A_INIT, r); vectors++;
      if (r !== m) begin errors++; $display("FAIL reset_init dut%0d: got %h, required %h", k, r, m); end
      bus_read(k, A_STAT, r); vectors++;
      if (r !== 32'h2) begin errors++; $display("FAIL reset_status dut%0d: got %h, required 2", k, r); end
      bus_read(k, A_RES, r); vectors++;
      if (r !== 32'h0) begin errors++; $display("FAIL reset_result dut%0d: got %h, required 0", k, r); end
    end
  endtask

  task automatic run_check_string(input int k);
    logic [31:0] r, exp, poly, init;
    logic [2:0]  cfg;
    case (k)
      4:       begin poly = 32'h1021;     init = 32'hFFFF;      cfg = 3'b000; exp = 32'h0000_29B1; end
      5:       begin poly = 32'h07;       init = 32'h00;        cfg = 3'b000; exp = 32'h0000_00F4; end
      default: begin poly = 32'h04C11DB7; init = 32'hFFFFFFFF;  cfg = 3'b111; exp = 32'hCBF4_3926; end
    endcase
    setup(k, poly, init, cfg);
    push(k, 32'h34333231, 2'b10);
    push(k, 32'h38373635, 2'b10);
    push(k, 32'h00000039, 2'b00);
    bus_read(k, A_RES, r);
    vectors++;
    if (r !== exp) begin errors++; $display("FAIL check_string dut%0d: got %h, required %h", k, r, exp); end
  endtask

  task automatic test_known();
    for (int k = 0; k < ND; k++) run_check_string(k);
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    bus_write(0, A_CTRL, 32'h2, 2'b10);
    bus_write(0, A_DATA, 32'h11223344, 2'b10);
    bus_write(0, A_DATA, 32'h55667788, 2'b10);
    bus_read(0, A_STAT, r); vectors++;
    if (r !== 32'h84) begin errors++; $display("FAIL ovf_full dut0: status %h, required 84", r); end
    vectors++;
    if (uo_out[0] !== 8'h02) begin errors++; $display("FAIL ovf_uo_out dut0: got %h, required 02", uo_out[0]); end
    bus_write(0, A_DATA, 32'h99, 2'b00);
    bus_read(0, A_STAT, r); vectors++;
    if (r !== 32'h8C) begin errors++; $display("FAIL ovf_drop dut0: status %h, required 8c", r); end
    bus_write(0, A_CTRL, 32'h2, 2'b10);
    bus_read(0, A_STAT, r); vectors++;
    if (r !== 32'h2) begin errors++; $display("FAIL ovf_clear dut0: status %h, required 2", r); end
    bus_write(0, A_DATA, 32'h01020304, 2'b10);
    bus_write(0, A_DATA, 32'h0506, 2'b01);
    bus_write(0, A_DATA, 32'h07, 2'b00);
    bus_write(0, A_DATA, 32'h0809, 2'b01);
    bus_read(0, A_STAT, r); vectors++;
    if (r !== 32'h78) begin errors++; $display("FAIL ovf_half_drop dut0: status %h, required 78", r); end
    bus_write(0, A_DATA, 32'h0A, 2'b00);
    bus_read(0, A_STAT, r); vectors++;
    if (r !== 32'h8C) begin errors++; $display("FAIL ovf_last_byte dut0: status %h, required 8c", r); end
    bus_write(0, A_CTRL, 32'h2, 2'b10);
  endtask

  task automatic test_stall();
    int cyc, nb;
    logic irq_early;
    logic [31:0] exp;
    for (int k = 0; k < 4; k++) begin
      nb = 32 / bpc_of(k);
      setup(k, 32'h04C11DB7, 32'hFFFFFFFF, 3'b111);
      push(k, $urandom(), 2'b10);
      exp = model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 3'b111);
      address[k] = A_RES; rd_n[k] = 2'b10;
      #1;
      cyc = 0; irq_early = 1'b0;
      while (!data_ready[k] && cyc < 400) begin
        irq_early = irq_early | irq[k];
        @(posedge clk); #2;
        cyc++;
      end
      vectors++;
      if (cyc < nb - 1 || cyc > nb + 1) begin
        errors++; $display("FAIL stall_cycles dut%0d: stalled %0d cycles, required %0d +-1", k, cyc, nb);
      end
      vectors++;
      if (data_out[k] !== exp) begin errors++; $display("FAIL stall_result dut%0d: got %h, required %h", k, data_out[k], exp); end
`ifdef CRCN_DONE_IRQ_EN
      vectors++;
      if (irq[k] !== 1'b1 || irq_early !== 1'b0) begin
        errors++; $display("FAIL stall_irq dut%0d: irq=%b early=%b, required 1/0", k, irq[k], irq_early);
      end
`else
      vectors++;
      if (irq[k] !== 1'b0) begin errors++; $display("FAIL irq_tied dut%0d: irq=%b, required 0", k, irq[k]); end
`endif
      @(posedge clk); #1;
      rd_n[k] = 2'b11;
`ifdef CRCN_DONE_IRQ_EN
      bus_write(k, A_CTRL, 32'h81, 2'b10);
      vectors++;
      if (irq[k] !== 1'b0) begin errors++; $display("FAIL irq_clear dut%0d: irq=%b, required 0", k, irq[k]); end
`endif
    end
  endtask

  task automatic test_enable_halt();
    logic [31:0] r, exp;
    setup(0, 32'h04C11DB7, 32'hFFFFFFFF, 3'b111);
    push(0, $urandom(), 2'b10);
    bus_write(0, A_CTRL, 32'h0, 2'b10);
    repeat (20) @(posedge clk);
    bus_read(0, A_STAT, r); vectors++;
    if (r !== 32'h30) begin errors++; $display("FAIL enable_halt dut0: status %h, required 30", r); end
    bus_write(0, A_CTRL, 32'h1, 2'b10);
    exp = model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 3'b111);
    bus_read(0, A_RES, r); vectors++;
    if (r !== exp) begin errors++; $display("FAIL enable_resume dut0: got %h, required %h", r, exp); end
  endtask

  task automatic test_random();
    logic [31:0] r, exp, poly, init, m;
    logic [2:0]  cfg;
    logic [1:0]  wn;
    int w, nw;
    for (int k = 0; k < ND; k++) begin
      for (int it = 0; it < 5; it++) begin
        w    = wid_of(k);
        m    = mask_of(w);
        poly = ($urandom() & m) | 32'h1;
        init = $urandom() & m;
        cfg  = 3'($urandom_range(0, 7));
        setup(k, poly, init, cfg);
        nw = $urandom_range(1, 6);
        for (int j = 0; j < nw; j++) begin
          wn = 2'($urandom_range(0, 2));
          push(k, $urandom(), wn);
        end
        exp = model_crc(w, poly, init, cfg);
        bus_read(k, A_RES, r); vectors++;
        if (r !== exp) begin
          errors++; $display("FAIL random_crc dut%0d it%0d cfg=%0d: got %h, required %h", k, it, cfg, r, exp);
        end
        bus_read(k, A_STAT, r); vectors++;
        if (r !== 32'h2) begin errors++; $display("FAIL random_status dut%0d it%0d: got %h, required 2", k, it, r); end
      end
    end
  endtask

  task automatic test_reset_mid();
    setup(0, 32'h04C11DB7, 32'hFFFFFFFF, 3'b111);
    bus_write(0, A_POLY, 32'h1EDC6F41, 2'b10);
    push(0, 32'hA5A5A5A5, 2'b10);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (uo_out[0][0] !== 1'b1) begin errors++; $display("FAIL mid_busy dut0: busy=%b, required 1", uo_out[0][0]); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (uo_out[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_pins dut0: uo_out=%h, required 00", uo_out[0]); end
    address[0] = A_STAT;
    #1;
    vectors++;
    if (data_out[0] !== 32'h2) begin errors++; $display("FAIL mid_reset_status dut0: got %h, required 2", data_out[0]); end
    address[0] = A_POLY;
    #1;
    vectors++;
    if (data_out[0] !== 32'h04C11DB7) begin errors++; $display("FAIL mid_reset_poly dut0: got %h, required 04c11db7", data_out[0]); end
    @(posedge clk); #1 rst_n = 1'b1;
    run_check_string(0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < ND; k++) begin
      address[k] = '0; data_in[k] = '0; wr_n[k] = 2'b11; rd_n[k] = 2'b11;
    end
    test_reset();
    test_known();
    test_overflow();
    test_stall();
    test_enable_halt();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
